dma_engine: RTL
===============

// Module: dma_engine
// PURPOSE
//  Bus-master DMA for the memory map: copies words from external cartridge ROM (32-bit word address) into any
//  memory-mapped region (program RAM, sprite/tile/palette VRAM, sound regs). Programmed by CPU through the four
//  registers decoded at DMA_REGS..+3 (dma_en, dma_mode); while busy it stalls the CPU and owns the memory bus.
// PARAMETERS
//  ROM_TIMEOUT  255  cycles to wait for rom_ack before aborting a transfer; 0 = wait forever
//  SRC_STEP     1    increment applied to source pointer per word (32-bit add)
//  DST_STEP     1    increment applied to destination pointer per word (16-bit add)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, synchronous, active-low
//  dma_en     in   1   CPU access hits DMA register window
//  dma_mode   in   2   register select: 0 SRC_L, 1 SRC_U, 2 DST, 3 AMT
//  memwrite   in   1   CPU write strobe
//  writedata  in   16  CPU write data
//  dma_rdata  out  16  register readback, registered
//  dma_busy   out  1   transfer in progress; CPU stall + bus mux select
//  dma_done   out  1   one-cycle pulse on completion or abort
//  rom_req    out  1   ROM read request, held until rom_ack
//  rom_addr   out  32  ROM word address
//  rom_ack    in   1   ROM data valid this cycle
//  rom_data   in   16  ROM read data
//  bus_we     out  1   memory-bus write strobe (one cycle per word)
//  bus_addr   out  16  memory-bus address
//  bus_wdata  out  16  memory-bus write data
// BEHAVIOUR
//  Reset (rst=0 at posedge, any state): state IDLE; src,dst,cnt,err,fill,data=0; all outputs 0.
//  Registers: write when dma_en & memwrite & state==IDLE; mode0 src[15:0], mode1 src[31:16], mode2 dst,
//   mode3 cnt<=writedata[14:0], fill<=writedata[15] (macro only), err<=0, start if writedata[14:0]!=0.
//   AMT write with count 0: err cleared, no transfer, no busy, no done. Register writes while busy: ignored.
//  Readback: dma_rdata updated every cycle (1-cycle latency) from dma_mode: 0 src[15:0], 1 src[31:16],
//   2 dst, 3 {err,cnt[14:0]}; reflects live pointers during transfer. Value independent of dma_en.
//  FSM: IDLE -> FETCH on valid AMT write (dma_busy=1 from next cycle).
//   FETCH: rom_req=1, rom_addr=src; on rom_ack latch rom_data -> WRITE. Timer counts FETCH cycles; at
//    ROM_TIMEOUT (if nonzero) without ack: err<=1, dma_done pulse, -> IDLE; pointers/cnt keep current values.
//   WRITE: bus_we=1, bus_addr=dst, bus_wdata=data for exactly one cycle; src+=SRC_STEP (32-bit wrap),
//    dst+=DST_STEP (16-bit wrap, 16'hFFFF -> 16'h0000), cnt-=1; if new cnt==0 -> IDLE + dma_done, else FETCH.
//  dma_busy=1 in FETCH and WRITE only; deasserts the cycle dma_done pulses. Min 2 cycles/word (ack same cycle).
//  rom_ack outside FETCH ignored. rom_req drops the cycle after ack. No write-back through CPU path while busy.
// CONFIGURATION
//  DMA_FILL_EN defined: AMT bit15=1 selects fill mode: FETCH skipped, WRITE uses src[15:0] as constant data,
//   src not incremented, rom_req never asserted; 1 cycle/word; readback unchanged.
//  DMA_FILL_EN undefined: AMT bit15 ignored (always copy); fill register absent.
// TESTING
//  1 SRC=0x0001_0000, DST=0x2000, AMT=3, ROM acks next cycle with 0xA1,0xA2,0xA3 -> bus_we at 0x2000..0x2002
//    with those data, one dma_done, readback mode3=0x0000, mode2=0x2003, busy low after.
//  2 AMT=0 -> no busy, no rom_req, no done; AMT write during busy (AMT=5 then AMT=9) -> exactly 5 words moved.
//  3 DST=0xFFFF, AMT=2 -> writes at 0xFFFF then 0x0000; SRC=0x0000_FFFF steps to 0x0001_0000 (carry to SRC_U).
//  4 rom_ack never asserted, ROM_TIMEOUT=255 -> abort after 255 FETCH cycles, readback mode3 bit15=1, cnt intact,
//    done pulse; next AMT write clears err.
//  5 rst low mid-transfer (after word 1 of 4) -> next cycle busy=0, rom_req=0, bus_we=0, all readback 0.
//  6 DMA_FILL_EN: SRC_L=0x00FF, DST=0x4400, AMT=0x8004 -> 4 consecutive cycles bus_we, data 0x00FF, no rom_req.

Source files
------------

// File: rtl/dma_engine.sv
// Bus-master DMA: copies words from cartridge ROM onto the memory bus, programmed through four CPU registers.
// Optional `DMA_FILL_EN adds a constant-fill mode selected by AMT bit 15.
module dma_engine #(
  parameter int          ROM_TIMEOUT = 255,
  parameter logic [31:0] SRC_STEP    = 32'd1,
  parameter logic [15:0] DST_STEP    = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_en,
  input  logic [1:0]  dma_mode,
  input  logic        memwrite,
  input  logic [15:0] writedata,
  output logic [15:0] dma_rdata,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  FETCH = 2'd1;
  localparam logic [1:0]  WRITE = 2'd2;
  localparam logic [31:0] TMO   = 32'(ROM_TIMEOUT);

  logic [1:0]  state;
  logic [31:0] src;
  logic [15:0] dst;
  logic [14:0] cnt;
  logic        err;
  logic [15:0] data;
  logic [31:0] timer;
  logic        cfg_wr;

`ifdef DMA_FILL_EN
  logic fill;
`else
  localparam logic fill = 1'b0;
`endif

  assign cfg_wr = dma_en & memwrite & (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      data      <= '0;
      timer     <= '0;
      dma_done  <= 1'b0;
      dma_rdata <= '0;
`ifdef DMA_FILL_EN
      fill      <= 1'b0;
`endif
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (cfg_wr) begin
            case (dma_mode)
              2'd0: src[15:0]  <= writedata;
              2'd1: src[31:16] <= writedata;
              2'd2: dst        <= writedata;
              2'd3: begin
                cnt <= writedata[14:0];
                err <= 1'b0;
`ifdef DMA_FILL_EN
                fill <= writedata[15];
                if (writedata[14:0] != 15'd0) state <= writedata[15] ? WRITE : FETCH;
`else
                if (writedata[14:0] != 15'd0) state <= FETCH;
`endif
              end
            endcase
          end
        end
        FETCH: begin
          if (rom_ack) begin
            data  <= rom_data;
            timer <= '0;
            state <= WRITE;
          end else if ((TMO != 32'd0) && (timer == TMO - 32'd1)) begin
            // Abort leaves pointers and count where they stopped so software can inspect them.
            err      <= 1'b1;
            dma_done <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        WRITE: begin
          timer <= '0;
          dst   <= dst + DST_STEP;
          if (!fill) src <= src + SRC_STEP;
          cnt <= cnt - 15'd1;
          if (cnt == 15'd1) begin
            state    <= IDLE;
            dma_done <= 1'b1;
          end else begin
            state <= fill ? WRITE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase

      case (dma_mode)
        2'd0: dma_rdata <= src[15:0];
        2'd1: dma_rdata <= src[31:16];
        2'd2: dma_rdata <= dst;
        2'd3: dma_rdata <= {err, cnt};
      endcase
    end
  end

  assign dma_busy  = (state != IDLE);
  assign rom_req   = (state == FETCH);
  assign rom_addr  = rom_req ? src : 32'd0;
  assign bus_we    = (state == WRITE);
  assign bus_addr  = bus_we ? dst : 16'd0;
  assign bus_wdata = bus_we ? (fill ? src[15:0] : data) : 16'd0;

endmodule
